// File: rtl/regs_mp_clr_if.sv
// Bus bundle for regs_mp_clr: two write ports, NR packed read ports and the busy flag.
interface regs_mp_clr_if #(
    parameter int W     = 32,
    parameter int DEPTH = 32,
    parameter int NR    = 2
);
    localparam int AW = $clog2(DEPTH);

    logic             busy;
    logic             en4w0;
    logic [AW-1:0]    addr_w0;
    logic [W-1:0]     data_i0;
    logic             en4w1;
    logic [AW-1:0]    addr_w1;
    logic [W-1:0]     data_i1;
    logic [NR*AW-1:0] addr_r;
    logic [NR*W-1:0]  data_o;

    modport master (
        input  busy, data_o,
        output en4w0, addr_w0, data_i0, en4w1, addr_w1, data_i1, addr_r
    );

    modport slave (
        output busy, data_o,
        input  en4w0, addr_w0, data_i0, en4w1, addr_w1, data_i1, addr_r
    );
endinterface

// File: rtl/regs_mp_clr.sv
// Multi-port register file with sequential hardware clear after reset and optional zero entry 0.
// Define REGS_MP_BYPASS_EN to forward same-cycle RUN writes to matching read ports.
module regs_mp_clr #(
    parameter int W       = 32,
    parameter int DEPTH   = 32,
    parameter int NR      = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic          clk,
    input  logic          rst,
    regs_mp_clr_if.slave  bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rf_q [DEPTH];
    logic [W-1:0]  rf_d [DEPTH];

    logic                 busy;
    logic                 wr0_ok, wr1_ok;
    logic [NR-1:0][W-1:0] rd_all;

    // Entry 0 is not addressable when it is hardwired to zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_X) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    assign busy     = rst || (state_q == CLEAR);
    assign bus.busy = busy;
    assign wr0_ok   = bus.en4w0 && !busy && addr_ok(bus.addr_w0);
    assign wr1_ok   = bus.en4w1 && !busy && addr_ok(bus.addr_w1);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        rf_d    = rf_q;
        if (!rst) begin
            unique case (state_q)
                CLEAR: begin
                    rf_d[cnt_q] = '0;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = RUN;
                end
                RUN: begin
                    if (wr0_ok) rf_d[bus.addr_w0] = bus.data_i0;
                    if (wr1_ok) rf_d[bus.addr_w1] = bus.data_i1;
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the array has no reset term; the clear sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic [W-1:0]  rd;

        assign ra = bus.addr_r[k*AW +: AW];

        always_comb begin
            rd = '0;
            if (!busy && addr_ok(ra)) begin
                rd = rf_q[ra];
`ifdef REGS_MP_BYPASS_EN
                if (wr1_ok && (bus.addr_w1 == ra))      rd = bus.data_i1;
                else if (wr0_ok && (bus.addr_w0 == ra)) rd = bus.data_i0;
`endif
            end
        end

        assign rd_all[k] = rd;
    end

    assign bus.data_o = rd_all;
endmodule
